// File: rtl/data_bus_master_pkg.sv
// Shared types and constants for the data bus master: FSM states, error bit
// indices, default parameters and the registered command payload.
package data_bus_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned ERR_W  = 2;

    localparam int unsigned ERR_UNEXP_RVALID = 0;
    localparam int unsigned ERR_TIMEOUT      = 1;

    localparam int unsigned DEF_MAX_OUTSTANDING = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/data_bus_master_fifo.sv
// In-order tracking FIFO for granted requests; tolerates push and pop in the
// same cycle even when full.
module data_bus_master_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_c_o,
    output logic             full_c_o,
    output logic             empty_c_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // Pointer wrap that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_c_o = (cnt_q == '0);
    assign full_c_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_pop    = pop_i && !empty_c_o;
    assign do_push   = push_i && (!full_c_o || do_pop);
    assign rdata_c_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push != do_pop) begin
                cnt_q <= do_push ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_bus_master.sv
// Single-initiator data bus master with in-order response tracking.
// Define DATA_BUS_MASTER_TIMEOUT_EN to enable the grant-to-rvalid timeout (err_o[1]).
module data_bus_master
    import data_bus_master_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [BE_W-1:0]   cmd_be_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [BE_W-1:0]   data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_we_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [ERR_W-1:0]  err_o,
    output logic              idle_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e             state_q, state_d;
    cmd_t               bus_q, bus_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               idle_q, idle_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               gnt_ok;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_we;
    logic               fifo_full;
    logic               fifo_empty;
    logic               unexp_rvalid;
    logic               tmo_hit;

    data_bus_master_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_we_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (fifo_push),
        .wdata_i   (bus_q.we),
        .pop_i     (fifo_pop),
        .rdata_c_o (fifo_we),
        .full_c_o  (fifo_full),
        .empty_c_o (fifo_empty)
    );

    // Request FSM: latch command on accept, hold it on the bus until granted.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        bus_d   = bus_q;
        gnt_ok  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state_d     = REQ;
                    req_d       = 1'b1;
                    bus_d.we    = cmd_we_i;
                    bus_d.addr  = cmd_addr_i;
                    bus_d.be    = cmd_be_i;
                    bus_d.wdata = cmd_wdata_i;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    gnt_ok  = 1'b1;
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Outstanding tracking, response capture and status for the next cycle.
    always_comb begin
        fifo_pop     = data_rvalid_i && !fifo_empty;
        unexp_rvalid = data_rvalid_i && fifo_empty;
        fifo_push    = gnt_ok && (!fifo_full || fifo_pop);
        cnt_d        = cnt_q;
        if (fifo_push && !fifo_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (fifo_pop && !fifo_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        ready_d     = (state_d == IDLE) && (cnt_d < CNT_W'(MAX_OUTSTANDING));
        idle_d      = (state_d == IDLE) && (cnt_d == '0);
        rsp_valid_d = fifo_pop;
        rsp_we_d    = fifo_pop && fifo_we;
        rsp_rdata_d = (fifo_pop && !fifo_we) ? data_rdata_i : '0;
    end

    always_comb begin
        err_d = err_q;
        if (unexp_rvalid) begin
            err_d[ERR_UNEXP_RVALID] = 1'b1;
        end
        if (tmo_hit) begin
            err_d[ERR_TIMEOUT] = 1'b1;
        end
    end

`ifdef DATA_BUS_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts from the grant edge so err_o[1] shows TIMEOUT_CYCLES after the grant.
    always_comb begin
        tmo_d = tmo_q;
        if (data_rvalid_i || (cnt_d == '0)) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_d == TMO_W'(TIMEOUT_CYCLES));
`else
    // Timeout supervision compiled out; the limit only keeps the parameter referenced.
    assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // cmd_ready_o stays low for the first cycle out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            idle_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            idle_q      <= idle_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign data_req_o   = req_q;
    assign data_addr_o  = bus_q.addr;
    assign data_we_o    = bus_q.we;
    assign data_be_o    = bus_q.be;
    assign data_wdata_o = bus_q.wdata;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_we_o     = rsp_we_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign err_o        = err_q;
    assign idle_o       = idle_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Bench for data_bus_master: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_data_bus_master;

    localparam int unsigned MAXO = 2;
    localparam int unsigned TMO  = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_we_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  err_o;
    logic        idle_o;

    data_bus_master #(
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_be_i      (cmd_be_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_we_o      (rsp_we_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .err_o         (err_o),
        .idle_o        (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending-request slot plus a queue of granted we bits.
    bit          m_valid = 1'b0;
    bit          m_busy, m_we, m_ready, m_idle;
    logic [31:0] m_addr, m_wdata, m_rsp_rdata;
    logic [3:0]  m_be;
    bit          m_rsp_valid, m_rsp_we;
    logic [1:0]  m_err;
    int unsigned m_tmo;
    bit          q[$];
    bit          m_acc, m_gnt, m_w;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_valid = 1'b1;
            m_busy = 0; m_we = 0; m_addr = '0; m_be = '0; m_wdata = '0;
            q.delete();
            m_ready = 0; m_idle = 1;
            m_rsp_valid = 0; m_rsp_we = 0; m_rsp_rdata = '0;
            m_err = '0; m_tmo = 0;
        end else if (m_valid) begin
            m_acc = m_ready && cmd_valid_i;
            m_gnt = m_busy && data_gnt_i;
            m_rsp_valid = 0; m_rsp_we = 0; m_rsp_rdata = '0;
            if (data_rvalid_i) begin
                if (q.size() == 0) begin
                    m_err[0] = 1'b1;
                end else begin
                    m_w = q.pop_front();
                    m_rsp_valid = 1;
                    m_rsp_we = m_w;
                    m_rsp_rdata = m_w ? 32'h0 : data_rdata_i;
                end
            end
            if (m_gnt) begin
                q.push_back(m_we);
                m_busy = 0;
            end else if (m_acc) begin
                m_busy = 1;
                m_we = cmd_we_i; m_addr = cmd_addr_i; m_be = cmd_be_i; m_wdata = cmd_wdata_i;
            end
            m_ready = !m_busy && (q.size() < MAXO);
            m_idle  = !m_busy && (q.size() == 0);
`ifdef DATA_BUS_MASTER_TIMEOUT_EN
            if (data_rvalid_i || q.size() == 0) m_tmo = 0;
            else if (m_tmo < TMO) m_tmo++;
            if (m_tmo == TMO) m_err[1] = 1'b1;
`endif
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("data_req",   32'(data_req_o),   32'(m_busy));
            chk("data_addr",  data_addr_o,       m_addr);
            chk("data_we",    32'(data_we_o),    32'(m_we));
            chk("data_be",    32'(data_be_o),    32'(m_be));
            chk("data_wdata", data_wdata_o,      m_wdata);
            chk("cmd_ready",  32'(cmd_ready_o),  32'(m_ready));
            chk("idle",       32'(idle_o),       32'(m_idle));
            chk("rsp_valid",  32'(rsp_valid_o),  32'(m_rsp_valid));
            chk("rsp_we",     32'(rsp_we_o),     32'(m_rsp_we));
            chk("rsp_rdata",  rsp_rdata_o,       m_rsp_rdata);
            chk("err",        32'(err_o),        32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic reset_dut();
        rst_i = 1; cmd_valid_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        cyc();
        rst_i = 0;
    endtask

    task automatic send_cmd(input bit we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        bit ok;
        ok = 0;
        cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wdata;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready_o) begin
                ok = 1;
                cyc();
                break;
            end
            cyc();
        end
        cmd_valid_i = 0;
        if (!ok) chk("cmd_accept_bound", 32'(ok), 32'h1);
    endtask

    task automatic grant_now();
        data_gnt_i = 1;
        cyc();
        data_gnt_i = 0;
    endtask

    task automatic rvalid_now(input logic [31:0] rd);
        data_rvalid_i = 1; data_rdata_i = rd;
        cyc();
        data_rvalid_i = 0;
    endtask

    bit last_acc;

    initial begin
        // Reset values
        rst_i = 1;
        cyc();
        cyc();
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
        chk("rst_idle",      32'(idle_o),      32'h1);
        chk("rst_data_req",  32'(data_req_o),  32'h0);
        chk("rst_err",       32'(err_o),       32'h0);
        rst_i = 0;

        // Read with same-cycle grant, rvalid one cycle later
        send_cmd(0, 32'h0000_1000, 4'hF, 32'h0);
        chk("rd_req",  32'(data_req_o), 32'h1);
        chk("rd_addr", data_addr_o,     32'h0000_1000);
        grant_now();
        chk("rd_req_drop", 32'(data_req_o), 32'h0);
        rvalid_now(32'hDEAD_BEEF);
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("rd_rsp_rdata", rsp_rdata_o,      32'hDEAD_BEEF);
        chk("rd_rsp_we",    32'(rsp_we_o),    32'h0);

        // Write with grant withheld for 3 cycles
        send_cmd(1, 32'h1000_0000, 4'h1, 32'h41);
        for (int i = 0; i < 4; i++) begin
            chk("wr_req_held", 32'(data_req_o),   32'h1);
            chk("wr_addr",     data_addr_o,       32'h1000_0000);
            chk("wr_be",       32'(data_be_o),    32'h1);
            chk("wr_wdata",    data_wdata_o,      32'h41);
            data_gnt_i = (i == 3);
            cyc();
        end
        data_gnt_i = 0;
        rvalid_now(32'h1234_5678);
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("wr_rsp_we",    32'(rsp_we_o),    32'h1);
        chk("wr_rsp_rdata", rsp_rdata_o,      32'h0);

        // Two outstanding reads, in-order responses
        send_cmd(0, 32'h2000, 4'hF, 0);
        grant_now();
        send_cmd(0, 32'h2004, 4'hF, 0);
        grant_now();
        chk("os2_cmd_ready", 32'(cmd_ready_o), 32'h0);
        chk("os2_idle",      32'(idle_o),      32'h0);
        cyc();
        chk("os2_cmd_ready_hold", 32'(cmd_ready_o), 32'h0);
        rvalid_now(32'h1);
        chk("os2_first", rsp_rdata_o, 32'h1);
        rvalid_now(32'h2);
        chk("os2_second", rsp_rdata_o, 32'h2);
        chk("os2_idle_after", 32'(idle_o), 32'h1);

        // Grant of second request in the same cycle as rvalid of the first
        send_cmd(0, 32'h3000, 4'hF, 0);
        grant_now();
        send_cmd(0, 32'h3004, 4'hF, 0);
        data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'hA;
        cyc();
        data_gnt_i = 0; data_rvalid_i = 0;
        chk("ovl_rsp_a",     rsp_rdata_o,      32'hA);
        chk("ovl_cmd_ready", 32'(cmd_ready_o), 32'h1);
        chk("ovl_idle",      32'(idle_o),      32'h0);
        rvalid_now(32'hB);
        chk("ovl_rsp_b", rsp_rdata_o, 32'hB);
        chk("ovl_idle_after", 32'(idle_o), 32'h1);

        // Unexpected rvalid, then reset mid-request
        rvalid_now(32'h55);
        chk("unexp_err",       32'(err_o),       32'h1);
        chk("unexp_rsp_valid", 32'(rsp_valid_o), 32'h0);
        send_cmd(1, 32'h4000, 4'h3, 32'h77);
        chk("mid_req", 32'(data_req_o), 32'h1);
        rst_i = 1;
        cyc();
        rst_i = 0;
        chk("mr_req",   32'(data_req_o),   32'h0);
        chk("mr_addr",  data_addr_o,       32'h0);
        chk("mr_we",    32'(data_we_o),    32'h0);
        chk("mr_be",    32'(data_be_o),    32'h0);
        chk("mr_wdata", data_wdata_o,      32'h0);
        chk("mr_rsp",   32'({rsp_valid_o, rsp_we_o}), 32'h0);
        chk("mr_rdata", rsp_rdata_o,       32'h0);
        chk("mr_err",   32'(err_o),        32'h0);
        chk("mr_idle",  32'(idle_o),       32'h1);
        chk("mr_ready", 32'(cmd_ready_o),  32'h0);
        rvalid_now(32'h66);
        chk("post_rst_rvalid_err", 32'(err_o), 32'h1);

`ifdef DATA_BUS_MASTER_TIMEOUT_EN
        // Unanswered read: timeout flag exactly TMO cycles after the grant
        reset_dut();
        send_cmd(0, 32'h5000, 4'hF, 0);
        grant_now();
        for (int k = 1; k < TMO; k++) begin
            chk("tmo_not_yet", 32'(err_o[1]), 32'h0);
            cyc();
        end
        chk("tmo_hit", 32'(err_o[1]), 32'h1);
`endif

        // Randomized traffic against the model
        reset_dut();
        last_acc = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!cmd_valid_i || last_acc) begin
                cmd_valid_i = ($urandom_range(0, 99) < 60);
                cmd_we_i    = 1'($urandom_range(0, 1));
                cmd_addr_i  = $urandom;
                cmd_be_i    = 4'($urandom_range(0, 15));
                cmd_wdata_i = $urandom;
            end
            data_gnt_i    = ($urandom_range(0, 99) < 40);
            data_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 99) < 35)
                                           : ($urandom_range(0, 499) == 0);
            data_rdata_i  = $urandom;
            rst_i         = ($urandom_range(0, 399) == 0);
            last_acc      = cmd_valid_i && cmd_ready_o && !rst_i;
            cyc();
        end
        cmd_valid_i = 0; data_gnt_i = 0; data_rvalid_i = 0; rst_i = 0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
